agc_abs_envelope: RTL and testbench
===================================

Name: agc_abs_envelope

Overview:
Multi-channel, parametrised absolute-value and envelope stage for the AGC front end.
- Per channel, computes a saturating |x| of signed input samples.
- Accumulates each channel's |x| over a fixed window of 2^WIN_LOG2 valid samples.
- Emits a per-window envelope as either the peak or the truncated mean.
- Sits between the ADC sample path and the AGC gain-control loop, which consumes op_env/op_env_valid.

Parameters:
- DATA_W, 12: sample width, signed two's complement in, unsigned magnitude out.
- NUM_CH, 2: number of parallel channels, packed in ports with ch0 in the LSBs.
- WIN_LOG2, 4: log2 of the envelope window length in valid samples; legal range 1..8.

Ports:
- ip_clock, in, 1: all registers update on its falling edge.
- ip_reset, in, 1: reset ip_reset, asynchronous, active-low.
- ip_valid, in, 1: qualifies ip_data; all channels are sampled together.
- ip_data, in, NUM_CH*DATA_W: signed samples, channel k at bits [k*DATA_W +: DATA_W].
- ip_mode, in, 1: 0 = peak envelope, 1 = mean envelope; sampled only at window start.
- ip_clear, in, 1: synchronous flush of the envelope state and sticky flags.
- op_abs, out, NUM_CH*DATA_W: registered saturating |x| per channel.
- op_abs_valid, out, 1: one-cycle pulse qualifying op_abs.
- op_env, out, NUM_CH*DATA_W: per-channel envelope, held between windows.
- op_env_valid, out, 1: one-cycle pulse when op_env updates.
- op_sat, out, NUM_CH: sticky per-channel flag; set when the input equals -2^(DATA_W-1).

Behaviour:
- Reset (ip_reset=0, asynchronous):
  - op_abs, op_env, op_sat = 0; op_abs_valid, op_env_valid = 0.
  - Window counter, accumulators and latched mode = 0.
  - Reset mid-window discards the partial window.
- Abs stage, latency 1:
  - ip_valid=1 at edge n gives op_abs/op_abs_valid at edge n+1.
  - x >= 0: output x. x < 0: output -x.
  - x = -2^(DATA_W-1): output 2^(DATA_W-1)-1 and set op_sat[k].
  - op_abs holds its last value when ip_valid=0; op_abs_valid drops to 0.
- Envelope stage, driven by op_abs_valid:
  - Counter cnt is WIN_LOG2 bits, shared by all channels, and advances only on op_abs_valid.
  - When cnt=0 and op_abs_valid=1: latch ip_mode (window start). ip_mode changes mid-window take effect at the next window.
  - Peak mode: acc_k = max(acc_k, op_abs_k); acc_k is cleared to the first sample at window start.
  - Mean mode: acc_k is DATA_W+WIN_LOG2 bits, unsigned, initialised to the first sample at window start, then summed.
  - On op_abs_valid with cnt = 2^WIN_LOG2-1, at the next edge:
    - op_env_k = peak, or (sum including the final sample) >> WIN_LOG2 with truncation.
    - op_env_valid pulses for 1 cycle.
    - cnt wraps to 0.
  - End-to-end latency: last ip_valid of the window at edge n gives op_env_valid at edge n+2.
  - Gaps in ip_valid are allowed; the window counts valid samples, not cycles.
- ip_clear (priority over accumulation):
  - At the edge: cnt=0, acc=0, op_sat=0, op_env_valid=0.
  - op_env keeps its previous value.
  - An op_abs_valid coinciding with ip_clear is discarded by the envelope stage.
  - The abs stage is not flushed; a sample on ip_valid during clear propagates and becomes the first sample of the new window.
- Simultaneous events:
  - A saturating sample in the same cycle as ip_clear: clear wins for the flag already held; the new sample's flag sets one edge later, via the abs stage.
  - Window completion and ip_clear in the same cycle: no op_env update.
- Arithmetic:
  - All magnitudes are unsigned, DATA_W bits.
  - The mean never exceeds 2^(DATA_W-1)-1.
  - No overflow is possible in acc, given its width.

Test Plan:
Bench uses DATA_W=12, NUM_CH=2, WIN_LOG2=2.
- Abs: ch0=0xFFB (-5), ch1=0x007, ip_valid 1 cycle -> next edge: op_abs ch0=5, ch1=7; op_abs_valid=1 for exactly 1 cycle; op_sat=0.
- Saturation: ch0=0x800 -> op_abs ch0=0x7FF, op_sat[0]=1, held through later samples. Then ip_clear -> op_sat=00.
- Peak mode (ip_mode=0):
  - ch0 samples 3, -9, 4, 2 with ch1=0, with 1-cycle gaps between samples -> 2 edges after the 4th ip_valid: op_env ch0=9, ch1=0; op_env_valid pulses once.
  - op_env holds 9 afterwards.
- Mean mode (ip_mode=1):
  - ch0 1,2,3,-6 -> op_env ch0=3.
  - ch1 1,1,1,2 -> op_env ch1=1 (truncation).
  - ip_mode toggled to 0 after the 2nd sample -> result still the mean; the next window is peak.
- Clear mid-window:
  - Peak mode, ch0 samples 20, 30, then ip_clear, then 8, 1, 2, 3 -> op_env ch0=8 after the 4th post-clear sample.
  - No op_env_valid between the clear and that point.
- Async reset:
  - Drop ip_reset mid-window with op_env=9 -> all outputs 0 immediately.
  - After release, a full 4-sample window of 5s -> op_env=5.

Source files
------------

// File: rtl/agc_abs_envelope.sv
// agc_abs_envelope: per-channel saturating |x| followed by a windowed peak/mean envelope.
// All state updates on the falling edge of ip_clock.
module agc_abs_envelope #(
    parameter int DATA_W   = 12,
    parameter int NUM_CH   = 2,
    parameter int WIN_LOG2 = 4
) (
    input  logic                     ip_clock,
    input  logic                     ip_reset,
    input  logic                     ip_valid,
    input  logic [NUM_CH*DATA_W-1:0] ip_data,
    input  logic                     ip_mode,
    input  logic                     ip_clear,
    output logic [NUM_CH*DATA_W-1:0] op_abs,
    output logic                     op_abs_valid,
    output logic [NUM_CH*DATA_W-1:0] op_env,
    output logic                     op_env_valid,
    output logic [NUM_CH-1:0]        op_sat
);
    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

    logic [NUM_CH*DATA_W-1:0] abs_d, abs_q, env_d, env_q;
    logic [NUM_CH*ACC_W-1:0]  acc_d, acc_q, nxt;
    logic [NUM_CH-1:0]        satp_d, satp_q, sat_d, sat_q;
    logic [WIN_LOG2-1:0]      cnt_d, cnt_q;
    logic                     abs_valid_q, mode_d, mode_q, env_valid_d, env_valid_q;
    logic                     take, start, last;

    always_comb begin
        take        = abs_valid_q & ~ip_clear;
        start       = cnt_q == '0;
        last        = &cnt_q;
        cnt_d       = ip_clear ? '0 : take ? cnt_q + WIN_LOG2'(1) : cnt_q;
        mode_d      = take & start ? ip_mode : mode_q;
        env_valid_d = take & last;
        // A saturating sample reaches the sticky flag via the abs register, so a clear only wins over flags already held
        sat_d       = ip_clear ? '0 : sat_q | satp_q;
        abs_d       = abs_q;
        satp_d      = '0;
        nxt         = '0;
        acc_d       = acc_q;
        env_d       = env_q;
        for (int k = 0; k < NUM_CH; k++) begin
            abs_d[k*DATA_W +: DATA_W] = !ip_valid ? abs_q[k*DATA_W +: DATA_W] :
                                        !ip_data[k*DATA_W+DATA_W-1] ? ip_data[k*DATA_W +: DATA_W] :
                                        ip_data[k*DATA_W +: DATA_W] == MIN_V ? MAX_V :
                                        -ip_data[k*DATA_W +: DATA_W];
            satp_d[k] = ip_valid & (ip_data[k*DATA_W +: DATA_W] == MIN_V);
            nxt[k*ACC_W +: ACC_W] = start ? ACC_W'(abs_q[k*DATA_W +: DATA_W]) :
                                    mode_q ? acc_q[k*ACC_W +: ACC_W] + ACC_W'(abs_q[k*DATA_W +: DATA_W]) :
                                    ACC_W'(abs_q[k*DATA_W +: DATA_W] > acc_q[k*ACC_W +: DATA_W] ?
                                           abs_q[k*DATA_W +: DATA_W] : acc_q[k*ACC_W +: DATA_W]);
            acc_d[k*ACC_W +: ACC_W] = take ? nxt[k*ACC_W +: ACC_W] : ip_clear ? '0 : acc_q[k*ACC_W +: ACC_W];
            env_d[k*DATA_W +: DATA_W] = !(take & last) ? env_q[k*DATA_W +: DATA_W] :
                                        mode_q ? DATA_W'(nxt[k*ACC_W +: ACC_W] >> WIN_LOG2) :
                                        nxt[k*ACC_W +: DATA_W];
        end
    end

    always_ff @(negedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            abs_q       <= '0;
            abs_valid_q <= 1'b0;
            satp_q      <= '0;
            sat_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            env_q       <= '0;
            env_valid_q <= 1'b0;
        end else begin
            abs_q       <= abs_d;
            abs_valid_q <= ip_valid;
            satp_q      <= satp_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            env_q       <= env_d;
            env_valid_q <= env_valid_d;
        end
    end

    assign op_abs       = abs_q;
    assign op_abs_valid = abs_valid_q;
    assign op_env       = env_q;
    assign op_env_valid = env_valid_q;
    assign op_sat       = sat_q;
endmodule

// File: tb/tb_agc_abs_envelope.sv
// tb_agc_abs_envelope: directed and random stimulus checked every cycle against a window-queue model,
// plus literal expectations for the hand-worked cases.
module tb_agc_abs_envelope;
    logic        ip_clock = 1'b0, ip_reset = 1'b0, ip_valid = 1'b0, ip_mode = 1'b0, ip_clear = 1'b0;
    logic [23:0] ip_data = '0;
    logic [23:0] op_abs, op_env;
    logic        op_abs_valid, op_env_valid;
    logic [1:0]  op_sat;
    int          tests = 0, fails = 0;
    bit          checking = 1'b0;

    agc_abs_envelope #(.DATA_W(12), .NUM_CH(2), .WIN_LOG2(2)) dut (
        .ip_clock(ip_clock), .ip_reset(ip_reset), .ip_valid(ip_valid), .ip_data(ip_data),
        .ip_mode(ip_mode), .ip_clear(ip_clear), .op_abs(op_abs), .op_abs_valid(op_abs_valid),
        .op_env(op_env), .op_env_valid(op_env_valid), .op_sat(op_sat)
    );

    always #5 ip_clock = ~ip_clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] absf(input logic [11:0] x);
        int v;
        v = int'($signed(x));
        if (v == -2048) return 12'h7FF;
        return v < 0 ? 12'(-v) : 12'(v);
    endfunction

    // Reference: the window is a queue of magnitude vectors; the envelope is recomputed from it when full.
    logic [23:0] m_abs = '0, m_env = '0;
    logic        m_abs_v = 1'b0, m_env_v = 1'b0, m_mode = 1'b0;
    logic [1:0]  m_satp = '0, m_sat = '0;
    logic [23:0] win[$];

    initial forever begin
        @(negedge ip_clock or negedge ip_reset);
        if (!ip_reset) begin
            m_abs = '0; m_env = '0; m_abs_v = 0; m_env_v = 0; m_mode = 0; m_satp = '0; m_sat = '0;
            win.delete();
        end else begin
            m_env_v = 0;
            if (ip_clear) begin
                win.delete();
                m_sat = '0;
            end else begin
                m_sat = m_sat | m_satp;
                if (m_abs_v) begin
                    if (win.size() == 0) m_mode = ip_mode;
                    win.push_back(m_abs);
                    if (win.size() == 4) begin
                        for (int c = 0; c < 2; c++) begin
                            int mx, sum, v;
                            mx = 0; sum = 0;
                            foreach (win[i]) begin
                                v = int'(win[i][c*12 +: 12]);
                                sum += v;
                                if (v > mx) mx = v;
                            end
                            m_env[c*12 +: 12] = m_mode ? 12'(sum / 4) : 12'(mx);
                        end
                        m_env_v = 1;
                        win.delete();
                    end
                end
            end
            m_abs_v = ip_valid;
            m_satp = '0;
            if (ip_valid)
                for (int c = 0; c < 2; c++) begin
                    m_abs[c*12 +: 12] = absf(ip_data[c*12 +: 12]);
                    m_satp[c] = ip_data[c*12 +: 12] == 12'h800;
                end
        end
    end

    initial forever begin
        @(posedge ip_clock);
        if (checking) begin
            chk("abs", op_abs, m_abs);
            chk("abs_valid", op_abs_valid, m_abs_v);
            chk("env", op_env, m_env);
            chk("env_valid", op_env_valid, m_env_v);
            chk("sat", op_sat, m_sat);
        end
    end

    task automatic drive(input logic v, input logic [11:0] d0, input logic [11:0] d1, input logic clr);
        @(posedge ip_clock);
        ip_valid = v;
        ip_data  = {d1, d0};
        ip_clear = clr;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_abs"}, op_abs, 0);
        chk({nm, "_absv"}, op_abs_valid, 0);
        chk({nm, "_env"}, op_env, 0);
        chk({nm, "_envv"}, op_env_valid, 0);
        chk({nm, "_sat"}, op_sat, 0);
    endtask

    initial begin
        repeat (3) @(posedge ip_clock);
        chk_zero("reset");
        ip_reset = 1'b1;
        checking = 1'b1;
        // single negative sample
        drive(1, 12'hFFB, 12'h007, 0);
        drive(0, 0, 0, 0);
        chk("abs_basic", op_abs, {12'd7, 12'd5});
        chk("abs_basic_v", op_abs_valid, 1);
        chk("abs_basic_sat", op_sat, 0);
        drive(0, 0, 0, 0);
        chk("abs_drop_v", op_abs_valid, 0);
        chk("abs_hold", op_abs, {12'd7, 12'd5});
        // saturation and sticky flag
        drive(1, 12'h800, 12'h001, 0);
        drive(0, 0, 0, 0);
        chk("sat_abs", op_abs, {12'd1, 12'h7FF});
        drive(0, 0, 0, 0);
        chk("sat_set", op_sat, 2'b01);
        drive(1, 12'h005, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("sat_sticky", op_sat, 2'b01);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("sat_clear", op_sat, 2'b00);
        // peak window with gaps
        ip_mode = 0;
        drive(1, 12'd3, 0, 0);   drive(0, 0, 0, 0);
        drive(1, 12'hFF7, 0, 0); drive(0, 0, 0, 0);
        drive(1, 12'd4, 0, 0);   drive(0, 0, 0, 0);
        drive(1, 12'd2, 0, 0);   drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("peak_env", op_env, {12'd0, 12'd9});
        chk("peak_envv", op_env_valid, 1);
        drive(0, 0, 0, 0);
        chk("peak_hold", op_env, {12'd0, 12'd9});
        // mean window, mode dropped mid-window
        ip_mode = 1;
        drive(1, 12'd1, 12'd1, 0); drive(0, 0, 0, 0);
        drive(1, 12'd2, 12'd1, 0);
        ip_mode = 0;
        drive(1, 12'd3, 12'd1, 0);
        drive(1, 12'hFFA, 12'd2, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("mean_env", op_env, {12'd1, 12'd3});
        // clear mid-window, next window is peak
        drive(1, 12'd20, 0, 0); drive(0, 0, 0, 0);
        drive(1, 12'd30, 0, 0); drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(1, 12'd8, 0, 0); drive(1, 12'd1, 0, 0); drive(1, 12'd2, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("clear_no_update", op_env, {12'd1, 12'd3});
        drive(1, 12'd3, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("clear_env", op_env, {12'd0, 12'd8});
        chk("clear_envv", op_env_valid, 1);
        // async reset mid-window
        drive(1, 12'd9, 0, 0); drive(1, 12'd1, 0, 0); drive(1, 12'd1, 0, 0); drive(1, 12'd1, 0, 0);
        drive(1, 12'd5, 12'd5, 0); drive(1, 12'd5, 12'd5, 0);
        drive(1, 12'd5, 12'd5, 0);
        chk("pre_reset_env", op_env, {12'd0, 12'd9});
        #2 ip_reset = 1'b0;
        #1 chk_zero("async");
        drive(0, 0, 0, 0);
        ip_reset = 1'b1;
        repeat (4) drive(1, 12'd5, 12'd5, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("post_reset_env", op_env, {12'd5, 12'd5});
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [11:0] r0, r1;
            r0 = $urandom_range(0, 7) == 0 ? 12'h800 : 12'($urandom);
            r1 = $urandom_range(0, 7) == 0 ? 12'h800 : 12'($urandom);
            ip_mode = 1'($urandom);
            drive(1'($urandom_range(0, 3) != 0), r0, r1, $urandom_range(0, 24) == 0);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
